// File: rtl/jtag_tap_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_regs_if
// Description : Strobe, serial-data and debug-side bundle between tap_fsm,
//               the debug module and the JTAG TAP register block.
//               master : tap_fsm / debug side, drives strobes, tdi and
//                        user_cap_i, and observes the outputs.
//               slave  : jtag_tap_regs, consumes strobes and drives tdo,
//                        tdo_oe, instr_o, user_dr_o and user_upd_o.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtag_tap_regs_if #(
  parameter int IR_W   = 5,
  parameter int USER_W = 32
);
  logic              tdi;
  logic              ir_shift;
  logic              ir_clock;
  logic              ir_upd;
  logic              dr_shift;
  logic              dr_clock;
  logic              dr_upd;
  logic              jtag_rst;
  logic              irdr_select;
  logic              tdo_ena;
  logic [USER_W-1:0] user_cap_i;
  logic              tdo;
  logic              tdo_oe;
  logic [IR_W-1:0]   instr_o;
  logic [USER_W-1:0] user_dr_o;
  logic              user_upd_o;

  modport master (
    output tdi, ir_shift, ir_clock, ir_upd, dr_shift, dr_clock, dr_upd,
           jtag_rst, irdr_select, tdo_ena, user_cap_i,
    input  tdo, tdo_oe, instr_o, user_dr_o, user_upd_o
  );

  modport slave (
    input  tdi, ir_shift, ir_clock, ir_upd, dr_shift, dr_clock, dr_upd,
           jtag_rst, irdr_select, tdo_ena, user_cap_i,
    output tdo, tdo_oe, instr_o, user_dr_o, user_upd_o
  );
endinterface
`default_nettype wire

// File: rtl/jtag_tap_regs.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_regs
// Description : Instruction register, data-register bank (IDCODE, BYPASS,
//               USER) and TDO output stage of a JTAG TAP. Driven by the
//               state-decoded strobes of tap_fsm.
// Ports       : tck  - TAP clock
//               trst - asynchronous active-high reset
//               bus  - jtag_tap_regs_if.slave: strobes, tdi, user_cap_i in;
//                      tdo, tdo_oe, instr_o, user_dr_o, user_upd_o out
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_regs #(
  parameter int              IR_W         = 5,
  parameter int              USER_W       = 32,
  parameter logic [31:0]     IDCODE_VAL   = 32'h1000_0A6B,
  parameter logic [IR_W-1:0] INSTR_IDCODE = 5'h01,
  parameter logic [IR_W-1:0] INSTR_USER   = 5'h10,
  parameter logic [IR_W-1:0] INSTR_BYPASS = 5'h1F
) (
  input  wire logic     tck,
  input  wire logic     trst,
  jtag_tap_regs_if.slave bus
);

  // IEEE 1149.1 capture pattern for the IR: '01' in the two LSBs.
  localparam logic [IR_W-1:0] C_IR_CAPTURE = IR_W'(1);

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_t;

  logic [IR_W-1:0]   r_ir_sr;
  logic [IR_W-1:0]   r_instr;
  logic              r_bypass_sr;
  logic [31:0]       r_idcode_sr;
  logic [USER_W-1:0] r_user_sr;
  logic [USER_W-1:0] r_user_dr;
  logic              r_user_upd;
  logic              r_tdo;
  logic              r_tdo_oe;

  dr_sel_t           w_dr_sel;
  logic              w_dr_lsb;
  logic              w_ir_active;
  logic              w_ir_capture;
  logic              w_ir_shift;
  logic              w_dr_capture;
  logic              w_dr_shift;
  logic              w_dr_update;

  // Opcode decode; anything that is neither IDCODE nor USER is BYPASS,
  // which covers INSTR_BYPASS itself.
  always_comb begin
    w_dr_sel = SEL_BYPASS;
    if (r_instr == INSTR_IDCODE) begin
      w_dr_sel = SEL_IDCODE;
    end else if (r_instr == INSTR_USER) begin
      w_dr_sel = SEL_USER;
    end else if (r_instr == INSTR_BYPASS) begin
      w_dr_sel = SEL_BYPASS;
    end
  end

  // Any IR strobe masks the DR strobes: tap_fsm never asserts both groups,
  // and if it ever did the IR path is the one kept consistent.
  assign w_ir_active  = bus.ir_shift | bus.ir_clock | bus.ir_upd;
  assign w_ir_capture = bus.ir_clock & ~bus.ir_shift;
  assign w_ir_shift   = bus.ir_clock &  bus.ir_shift;
  assign w_dr_capture = ~w_ir_active & bus.dr_clock & ~bus.dr_shift;
  assign w_dr_shift   = ~w_ir_active & bus.dr_clock &  bus.dr_shift;
  assign w_dr_update  = ~w_ir_active & bus.dr_upd & (w_dr_sel == SEL_USER);

  // Instruction register and active instruction.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_ir_sr <= C_IR_CAPTURE;
      r_instr <= INSTR_IDCODE;
    end else if (bus.jtag_rst) begin
      r_ir_sr <= C_IR_CAPTURE;
      r_instr <= INSTR_IDCODE;
    end else begin
      if (w_ir_capture) begin
        r_ir_sr <= C_IR_CAPTURE;
      end else if (w_ir_shift) begin
        r_ir_sr <= {bus.tdi, r_ir_sr[IR_W-1:1]};
      end
      // Update uses the pre-edge IR contents.
      if (bus.ir_upd) begin
        r_instr <= r_ir_sr;
      end
    end
  end

  // Data-register bank; only the register selected by the active
  // instruction captures or shifts, the others hold.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_bypass_sr <= 1'b0;
      r_idcode_sr <= IDCODE_VAL;
      r_user_sr   <= '0;
      r_user_dr   <= '0;
      r_user_upd  <= 1'b0;
    end else if (bus.jtag_rst) begin
      r_bypass_sr <= 1'b0;
      r_idcode_sr <= IDCODE_VAL;
      r_user_sr   <= '0;
      r_user_dr   <= '0;
      r_user_upd  <= 1'b0;
    end else begin
      r_user_upd <= 1'b0;
      if (w_dr_capture) begin
        case (w_dr_sel)
          SEL_IDCODE: r_idcode_sr <= IDCODE_VAL;
          SEL_USER:   r_user_sr   <= bus.user_cap_i;
          default:    r_bypass_sr <= 1'b0;
        endcase
      end else if (w_dr_shift) begin
        case (w_dr_sel)
          SEL_IDCODE: r_idcode_sr <= {bus.tdi, r_idcode_sr[31:1]};
          SEL_USER:   r_user_sr   <= {bus.tdi, r_user_sr[USER_W-1:1]};
          default:    r_bypass_sr <= bus.tdi;
        endcase
      end
      if (w_dr_update) begin
        r_user_dr  <= r_user_sr;
        r_user_upd <= 1'b1;
      end
    end
  end

  always_comb begin
    w_dr_lsb = r_bypass_sr;
    case (w_dr_sel)
      SEL_IDCODE: w_dr_lsb = r_idcode_sr[0];
      SEL_USER:   w_dr_lsb = r_user_sr[0];
      default:    w_dr_lsb = r_bypass_sr;
    endcase
  end

  // TDO is launched on the falling edge so the shift-register LSB is
  // presented half a tck before the rising edge that shifts it out.
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else begin
      r_tdo_oe <= bus.tdo_ena;
      if (bus.tdo_ena) begin
        r_tdo <= bus.irdr_select ? r_ir_sr[0] : w_dr_lsb;
      end
    end
  end

  assign bus.tdo        = r_tdo;
  assign bus.tdo_oe     = r_tdo_oe;
  assign bus.instr_o    = r_instr;
  assign bus.user_dr_o  = r_user_dr;
  assign bus.user_upd_o = r_user_upd;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_regs
// Description : Self-checking bench for jtag_tap_regs: directed vector
//               table, randomized strobes against a reference model, and
//               hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_regs;
  localparam int         IR_W      = 5;
  localparam int         USER_W    = 32;
  localparam logic [31:0] IDCODE   = 32'h1000_0A6B;
  localparam logic [4:0] OP_IDCODE = 5'h01;
  localparam logic [4:0] OP_USER   = 5'h10;

  logic tck  = 1'b0;
  logic trst = 1'b1;

  jtag_tap_regs_if #(.IR_W(IR_W), .USER_W(USER_W)) bus ();

  jtag_tap_regs dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus.slave)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic        ir_shift, ir_clock, ir_upd;
    logic        dr_shift, dr_clock, dr_upd;
    logic        jtag_rst, irdr_select, tdo_ena, tdi;
    logic [31:0] cap;
    logic        chk_tdo, exp_tdo, exp_oe;
    logic [4:0]  exp_instr;
    logic [31:0] exp_udr;
    logic        exp_upd;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // builder state: what the outputs should read after each row
  logic [4:0]  b_instr = OP_IDCODE;
  logic [31:0] b_udr   = '0;
  logic [31:0] b_cap   = '0;

  // reference model state
  logic [31:0] m_dr [3];   // 0 = BYPASS, 1 = IDCODE, 2 = USER
  logic [4:0]  m_ir, m_instr;
  logic [31:0] m_udr;
  logic        m_upd, m_tdo, m_oe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [4:0] op);
    if (op == OP_IDCODE) return 1;
    if (op == OP_USER)   return 2;
    return 0;
  endfunction

  function automatic int width_of(input int k);
    return (k == 0) ? 1 : 32;
  endfunction

  task automatic model_soft_reset();
    m_ir = 5'd1; m_instr = OP_IDCODE;
    m_dr[0] = 0; m_dr[1] = IDCODE; m_dr[2] = 0;
    m_udr = 0; m_upd = 0;
  endtask

  task automatic model_reset();
    model_soft_reset();
    m_tdo = 0; m_oe = 0;
  endtask

  task automatic model_pos();
    int k;
    logic [4:0]  ir_old;
    logic [31:0] dr_old;
    m_upd = 0;
    if (bus.jtag_rst) begin
      model_soft_reset();
    end else if (bus.ir_shift || bus.ir_clock || bus.ir_upd) begin
      ir_old = m_ir;
      if (bus.ir_clock)
        m_ir = bus.ir_shift ? ((m_ir >> 1) + (bus.tdi ? 5'd16 : 5'd0)) : 5'd1;
      if (bus.ir_upd) m_instr = ir_old;
    end else begin
      k = kind_of(m_instr);
      dr_old = m_dr[k];
      if (bus.dr_clock) begin
        if (bus.dr_shift)
          m_dr[k] = (m_dr[k] >> 1) | (32'(bus.tdi) << (width_of(k) - 1));
        else
          m_dr[k] = (k == 1) ? IDCODE : (k == 2) ? bus.user_cap_i : 32'd0;
      end
      if (bus.dr_upd && k == 2) begin
        m_udr = dr_old;
        m_upd = 1;
      end
    end
  endtask

  task automatic model_neg();
    m_oe = bus.tdo_ena;
    if (bus.tdo_ena) m_tdo = bus.irdr_select ? m_ir[0] : m_dr[kind_of(m_instr)][0];
  endtask

  function automatic vec_t mk(input logic irs, irc, iru, drs, drc, dru, jr, sel, ena, t,
                              input logic chk_t, etdo, upd);
    vec_t v;
    v.ir_shift = irs; v.ir_clock = irc; v.ir_upd = iru;
    v.dr_shift = drs; v.dr_clock = drc; v.dr_upd = dru;
    v.jtag_rst = jr; v.irdr_select = sel; v.tdo_ena = ena; v.tdi = t;
    v.cap = b_cap; v.chk_tdo = chk_t; v.exp_tdo = etdo; v.exp_oe = ena;
    v.exp_instr = b_instr; v.exp_udr = b_udr; v.exp_upd = upd;
    return v;
  endfunction

  function automatic vec_t f_idle();                 return mk(0,0,0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic vec_t f_cir();                  return mk(0,1,0,0,0,0,0,1,0,0,0,0,0); endfunction
  function automatic vec_t f_sir(input logic t, e);  return mk(1,1,0,0,0,0,0,1,1,t,1,e,0); endfunction
  function automatic vec_t f_cdr();                  return mk(0,0,0,0,1,0,0,0,0,0,0,0,0); endfunction
  function automatic vec_t f_sdr(input logic t, e);  return mk(0,0,0,1,1,0,0,0,1,t,1,e,0); endfunction
  function automatic vec_t f_uir(input logic [4:0] op);
    b_instr = op;
    return mk(0,0,1,0,0,0,0,1,0,0,0,0,0);
  endfunction
  function automatic vec_t f_udr(input logic [31:0] val);
    if (b_instr == OP_USER) begin
      b_udr = val;
      return mk(0,0,0,0,0,1,0,0,0,0,0,0,1);
    end
    return mk(0,0,0,0,0,1,0,0,0,0,0,0,0);
  endfunction
  function automatic vec_t f_tlr();
    b_instr = OP_IDCODE; b_udr = 0;
    return mk(0,0,0,0,0,0,1,0,0,0,0,0,0);
  endfunction

  task automatic drive(input vec_t v);
    bus.ir_shift = v.ir_shift; bus.ir_clock = v.ir_clock; bus.ir_upd = v.ir_upd;
    bus.dr_shift = v.dr_shift; bus.dr_clock = v.dr_clock; bus.dr_upd = v.dr_upd;
    bus.jtag_rst = v.jtag_rst; bus.irdr_select = v.irdr_select;
    bus.tdo_ena = v.tdo_ena; bus.tdi = v.tdi; bus.user_cap_i = v.cap;
  endtask

  // One TAP state: inputs settle, falling edge launches TDO, rising edge
  // acts on the strobes. Checks land 1 time unit after each edge.
  task automatic run_row(input vec_t v, input bit use_tbl, input int idx);
    drive(v);
    @(negedge tck); model_neg(); #1;
    if (use_tbl) begin
      if (v.chk_tdo) chk($sformatf("row%0d_tdo", idx), 32'(bus.tdo), 32'(v.exp_tdo));
      chk($sformatf("row%0d_tdo_oe", idx), 32'(bus.tdo_oe), 32'(v.exp_oe));
    end else begin
      chk("mdl_tdo", 32'(bus.tdo), 32'(m_tdo));
      chk("mdl_tdo_oe", 32'(bus.tdo_oe), 32'(m_oe));
    end
    @(posedge tck); model_pos(); #1;
    if (use_tbl) begin
      chk($sformatf("row%0d_instr", idx), 32'(bus.instr_o), 32'(v.exp_instr));
      chk($sformatf("row%0d_user_dr", idx), bus.user_dr_o, v.exp_udr);
      chk($sformatf("row%0d_user_upd", idx), 32'(bus.user_upd_o), 32'(v.exp_upd));
    end else begin
      chk("mdl_instr", 32'(bus.instr_o), 32'(m_instr));
      chk("mdl_user_dr", bus.user_dr_o, m_udr);
      chk("mdl_user_upd", 32'(bus.user_upd_o), 32'(m_upd));
    end
  endtask

  task automatic load_ir(input logic [4:0] op, input bit use_tbl);
    logic [4:0] p;
    p = op;
    if (use_tbl) begin
      tbl.push_back(f_cir());
      for (int b = 0; b < 5; b++) tbl.push_back(f_sir(p[b], (b == 0)));
      tbl.push_back(f_uir(op));
    end else begin
      run_row(f_cir(), 0, 0);
      for (int b = 0; b < 5; b++) run_row(f_sir(p[b], 0), 0, 0);
      run_row(f_uir(op), 0, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat, exp;
    logic [3:0]  byp_in, byp_out;
    vec_t        v;
    int          r;
    logic [4:0]  op;

    drive(f_idle());
    #12;
    chk("reset_tdo", 32'(bus.tdo), 32'd0);
    chk("reset_tdo_oe", 32'(bus.tdo_oe), 32'd0);
    chk("reset_instr", 32'(bus.instr_o), 32'(OP_IDCODE));
    chk("reset_user_dr", bus.user_dr_o, 32'd0);
    chk("reset_user_upd", 32'(bus.user_upd_o), 32'd0);
    #1 trst = 1'b0;
    model_reset();

    // IDCODE scan straight out of reset
    tbl.push_back(f_idle()); tbl.push_back(f_idle()); tbl.push_back(f_cdr());
    exp = IDCODE;
    for (int k = 0; k < 32; k++) tbl.push_back(f_sdr(1'b0, exp[k]));
    tbl.push_back(f_idle());
    // IR scan to USER; TDO shows the 1,0,0,0,0 capture pattern
    load_ir(OP_USER, 1);
    tbl.push_back(f_idle());
    // USER capture/shift/update
    b_cap = 32'hCAFE_F00D; pat = 32'h1234_5678; exp = 32'hCAFE_F00D;
    tbl.push_back(f_cdr());
    for (int k = 0; k < 32; k++) tbl.push_back(f_sdr(pat[k], exp[k]));
    tbl.push_back(f_udr(32'h1234_5678));
    tbl.push_back(f_idle());
    // unlisted opcode selects BYPASS: 1-tck delay, first bit 0
    load_ir(5'h07, 1);
    tbl.push_back(f_cdr());
    byp_in = 4'b1101; byp_out = 4'b1010;   // bit0 first: in 1,0,1,1 / out 0,1,0,1
    for (int k = 0; k < 4; k++) tbl.push_back(f_sdr(byp_in[k], byp_out[k]));
    tbl.push_back(f_sdr(1'b0, 1'b1));
    tbl.push_back(f_idle());
    // USER update then soft reset from Test-Logic-Reset
    load_ir(OP_USER, 1);
    b_cap = 32'h0F0F_0F0F; pat = 32'hA5A5_A5A5; exp = 32'h0F0F_0F0F;
    tbl.push_back(f_cdr());
    for (int k = 0; k < 32; k++) tbl.push_back(f_sdr(pat[k], exp[k]));
    tbl.push_back(f_udr(32'hA5A5_A5A5));
    for (int k = 0; k < 5; k++) tbl.push_back(f_tlr());
    tbl.push_back(f_idle());

    foreach (tbl[i]) run_row(tbl[i], 1, i);

    // randomized strobes against the reference model
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) begin
        case ($urandom_range(0, 3))
          0:       op = OP_IDCODE;
          1:       op = OP_USER;
          2:       op = 5'h1F;
          default: op = 5'($urandom_range(0, 31));
        endcase
        load_ir(op, 0);
      end
      if ($urandom_range(0, 99) == 0) begin
        trst = 1'b1; #1 trst = 1'b0;
        model_reset();
      end
      v = f_idle();
      r = $urandom_range(0, 15);
      v.jtag_rst = ($urandom_range(0, 39) == 0);
      if (r < 4) begin
        v.ir_clock = ($urandom_range(0, 1) == 1);
        v.ir_shift = ($urandom_range(0, 1) == 1);
        v.ir_upd   = ($urandom_range(0, 5) == 0);
        v.irdr_select = 1'b1;
        v.dr_clock = ($urandom_range(0, 7) == 0);
      end else begin
        v.dr_clock = (r < 13);
        v.dr_shift = ($urandom_range(0, 4) != 0);
        v.dr_upd   = ($urandom_range(0, 7) == 0);
        v.irdr_select = ($urandom_range(0, 9) == 0);
      end
      v.tdo_ena = ($urandom_range(0, 3) != 0);
      v.tdi = ($urandom_range(0, 1) == 1);
      v.cap = $urandom();
      run_row(v, 0, c);
    end

    // asynchronous trst between edges in the middle of a USER shift
    run_row(f_tlr(), 0, 0);
    load_ir(OP_USER, 0);
    b_cap = 32'hFFFF_FFFF;
    run_row(f_cdr(), 0, 0);
    for (int k = 0; k < 32; k++) run_row(f_sdr(1'b1, 1'b1), 0, 0);
    run_row(f_udr(32'hFFFF_FFFF), 0, 0);
    run_row(f_cdr(), 0, 0);
    for (int k = 0; k < 3; k++) run_row(f_sdr(1'b1, 1'b1), 0, 0);
    chk("pre_trst_tdo", 32'(bus.tdo), 32'd1);
    chk("pre_trst_tdo_oe", 32'(bus.tdo_oe), 32'd1);
    chk("pre_trst_user_dr", bus.user_dr_o, 32'hFFFF_FFFF);
    #2 trst = 1'b1;
    #1;
    chk("trst_tdo", 32'(bus.tdo), 32'd0);
    chk("trst_tdo_oe", 32'(bus.tdo_oe), 32'd0);
    chk("trst_instr", 32'(bus.instr_o), 32'(OP_IDCODE));
    chk("trst_user_dr", bus.user_dr_o, 32'd0);
    chk("trst_user_upd", 32'(bus.user_upd_o), 32'd0);
    @(negedge tck); #2 trst = 1'b0;
    model_reset();
    // IDCODE is selected again and scans out from its captured value
    run_row(f_cdr(), 0, 0);
    for (int k = 0; k < 4; k++) run_row(f_sdr(1'b0, 1'b0), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
